mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter that shares one cache-line memory
// port among N_CH requesting cache controllers. It serves one line
// transaction at a time, and a watchdog aborts any transaction that the
// memory never acknowledges.
module mem_port_arbiter #(
  parameter int N_CH    = 2,
  parameter int ADDR_W  = 32,
  parameter int LINE_W  = 256,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [N_CH-1:0]          req_enable_i,
  input  logic [N_CH-1:0]          req_write_i,
  input  logic [N_CH*ADDR_W-1:0]   req_addr_i,
  input  logic [N_CH*LINE_W-1:0]   req_data_i,
  output logic [N_CH-1:0]          resp_ack_o,
  output logic [LINE_W-1:0]        resp_data_o,
  output logic [N_CH-1:0]          grant_o,
  output logic                     timeout_o,
  input  logic [LINE_W-1:0]        mem_data_i,
  input  logic                     mem_ack_i,
  output logic                     mem_enable_o,
  output logic                     mem_write_o,
  output logic [ADDR_W-1:0]        mem_addr_o,
  output logic [LINE_W-1:0]        mem_data_o
);

  localparam int PTR_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int WD_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit WD_EN = (TIMEOUT > 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [PTR_W-1:0]  owner_q, owner_d;
  logic [N_CH-1:0]   mask_q, mask_d;
  logic [WD_W-1:0]   wd_cnt_q, wd_cnt_d;
  logic [N_CH-1:0]   grant_q, grant_d;
  logic [N_CH-1:0]   resp_ack_q, resp_ack_d;
  logic [LINE_W-1:0] resp_data_q, resp_data_d;
  logic              timeout_q, timeout_d;
  logic              mem_enable_q, mem_enable_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0] mem_data_q, mem_data_d;

  logic [N_CH-1:0]   eligible;
  logic              win_found;
  logic [PTR_W-1:0]  win_idx;
  logic [PTR_W-1:0]  cand;
  logic [PTR_W-1:0]  ptr_after_owner;
  logic              wd_expired;

  // Round-robin search: first eligible channel starting at ptr, wrapping.
  always_comb begin
    eligible  = req_enable_i & ~mask_q;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < N_CH; i++) begin
      cand = PTR_W'((int'(ptr_q) + i) % N_CH);
      if (!win_found && eligible[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Pointer value that hands priority to the channel after the current owner.
  always_comb begin
    ptr_after_owner = (owner_q == PTR_W'(N_CH - 1)) ? '0 : owner_q + 1'b1;
  end

  // Watchdog fires on the BUSY cycle that would bring the count to TIMEOUT.
  always_comb begin
    wd_expired = WD_EN && ((wd_cnt_q + 1'b1) == WD_W'(TIMEOUT));
  end

  // Next-state logic, transaction latching and registered-output values.
  always_comb begin
    // NOTE: every _d gets a default before the case, so no path leaves one
    // unassigned and no latch is inferred.
    state_d      = state_q;
    ptr_d        = ptr_q;
    owner_d      = owner_q;
    mask_d       = '0;
    wd_cnt_d     = wd_cnt_q;
    grant_d      = grant_q;
    resp_ack_d   = '0;
    resp_data_d  = resp_data_q;
    timeout_d    = timeout_q;
    mem_enable_d = mem_enable_q;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;

    unique case (state_q)
      S_IDLE: begin
        wd_cnt_d = '0;
        if (win_found) begin
          owner_d      = win_idx;
          grant_d      = N_CH'(1) << win_idx;
          mem_enable_d = 1'b1;
          mem_write_d  = req_write_i[win_idx];
          mem_addr_d   = req_addr_i[int'(win_idx)*ADDR_W +: ADDR_W];
          mem_data_d   = req_data_i[int'(win_idx)*LINE_W +: LINE_W];
          state_d      = S_BUSY;
        end
      end

      S_BUSY: begin
        wd_cnt_d = wd_cnt_q + 1'b1;
        // An ack in the same cycle as expiry takes priority over the abort.
        // An aborted owner also loses its turn, so ptr moves on either way.
        if (mem_ack_i || wd_expired) begin
          state_d      = S_DONE;
          mem_enable_d = 1'b0;
          resp_ack_d   = grant_q;
          ptr_d        = ptr_after_owner;
          if (mem_ack_i) begin
            if (!mem_write_q) begin
              resp_data_d = mem_data_i;
            end
          end else begin
            timeout_d = 1'b1;
          end
        end
      end

      S_DONE: begin
        // The owner drops its request one cycle after the ack, so it is
        // masked for exactly the IDLE cycle that follows.
        mask_d  = grant_q;
        grant_d = '0;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      owner_q      <= '0;
      mask_q       <= '0;
      wd_cnt_q     <= '0;
      grant_q      <= '0;
      resp_ack_q   <= '0;
      timeout_q    <= 1'b0;
      mem_enable_q <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      // NOTE: the line-wide registers are cleared too, so no stale line is
      // ever visible on the memory or response ports after a reset.
      resp_data_q  <= '0;
      mem_data_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments make every flop capture pre-edge
      // values regardless of statement order.
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      owner_q      <= owner_d;
      mask_q       <= mask_d;
      wd_cnt_q     <= wd_cnt_d;
      grant_q      <= grant_d;
      resp_ack_q   <= resp_ack_d;
      timeout_q    <= timeout_d;
      mem_enable_q <= mem_enable_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      resp_data_q  <= resp_data_d;
      mem_data_q   <= mem_data_d;
    end
  end

  assign resp_ack_o   = resp_ack_q;
  assign resp_data_o  = resp_data_q;
  assign grant_o      = grant_q;
  assign timeout_o    = timeout_q;
  assign mem_enable_o = mem_enable_q;
  assign mem_write_o  = mem_write_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_data_o   = mem_data_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bench for mem_port_arbiter. It uses a
// two-channel instance with a 16-cycle watchdog for the cycle-table and
// corner sequences, and a four-channel instance for the pointer search.
module tb_mem_port_arbiter;

  localparam logic [255:0] DEAD   = {8{32'hDEAD_BEEF}};
  localparam logic [255:0] A5     = {32{8'hA5}};
  localparam logic [255:0] ALT    = {8{32'h5555_5555}};
  localparam logic [255:0] WDDATA = {8{32'h1234_5678}};
  localparam logic [255:0] D0     = {8{32'h0000_C0DE}};

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   req_enable, req_write;
  logic [63:0]  req_addr;
  logic [511:0] req_data;
  logic [1:0]   resp_ack, grant;
  logic [255:0] resp_data, mem_rdata, mem_wdata;
  logic         timeout, mem_ack, mem_enable, mem_write;
  logic [31:0]  mem_addr;

  logic [3:0]    en4, wr4, ack4, grant4;
  logic [127:0]  addr4;
  logic [1023:0] data4;
  logic [255:0]  rdata4, mem_rdata4, mem_wdata4;
  logic          to4, mem_ack4, mem_en4, mem_wr4;
  logic [31:0]   mem_addr4;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.N_CH(2), .ADDR_W(32), .LINE_W(256), .TIMEOUT(16)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_enable_i(req_enable), .req_write_i(req_write),
    .req_addr_i(req_addr), .req_data_i(req_data),
    .resp_ack_o(resp_ack), .resp_data_o(resp_data),
    .grant_o(grant), .timeout_o(timeout),
    .mem_data_i(mem_rdata), .mem_ack_i(mem_ack),
    .mem_enable_o(mem_enable), .mem_write_o(mem_write),
    .mem_addr_o(mem_addr), .mem_data_o(mem_wdata)
  );

  mem_port_arbiter #(.N_CH(4), .ADDR_W(32), .LINE_W(256), .TIMEOUT(64)) dut4 (
    .clk_i(clk), .rst_i(rst),
    .req_enable_i(en4), .req_write_i(wr4),
    .req_addr_i(addr4), .req_data_i(data4),
    .resp_ack_o(ack4), .resp_data_o(rdata4),
    .grant_o(grant4), .timeout_o(to4),
    .mem_data_i(mem_rdata4), .mem_ack_i(mem_ack4),
    .mem_enable_o(mem_en4), .mem_write_o(mem_wr4),
    .mem_addr_o(mem_addr4), .mem_data_o(mem_wdata4)
  );

  typedef struct {
    logic       rst;
    logic [1:0] en;
    logic [1:0] wr;
    logic       ack;
    logic       exp_en;
    logic [1:0] exp_grant;
    logic [1:0] exp_ack;
    logic       exp_to;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for mem_enable, then holds BUSY for 'delay' cycles,
  // acking in the last one and checking the latched request every cycle.
  task automatic serve(input int delay, input logic [31:0] ea, input logic ew,
                       input logic [255:0] ed, output int lat, output bit busy_ok);
    lat = 0;
    while (mem_enable !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    busy_ok = 1'b1;
    for (int k = 1; k <= delay; k++) begin
      busy_ok = busy_ok && (mem_enable === 1'b1) && (mem_addr === ea) &&
                (mem_write === ew) && (mem_wdata === ed);
      mem_ack = (k == delay);
      tick();
    end
    mem_ack = 1'b0;
  endtask

  task automatic serve4(output logic [3:0] g, output logic [31:0] a, output logic [255:0] d);
    int lat = 0;
    while (mem_en4 !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    g = grant4;
    a = mem_addr4;
    d = mem_wdata4;
    mem_ack4 = 1'b1;
    tick();
    mem_ack4 = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no end, expected finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    int lat;
    int n;
    bit ok;
    logic [1:0]   exp_g;
    logic [3:0]   g4;
    logic [31:0]  a4;
    logic [255:0] d4;

    //             rst   en     wr     ack  | en    grant  ack    to
    vecs[0]  = '{1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0};
    vecs[1]  = '{1'b0, 2'b01, 2'b00, 1'b0, 1'b1, 2'b01, 2'b00, 1'b0};
    vecs[2]  = '{1'b0, 2'b01, 2'b00, 1'b0, 1'b1, 2'b01, 2'b00, 1'b0};
    vecs[3]  = '{1'b0, 2'b01, 2'b00, 1'b1, 1'b0, 2'b01, 2'b01, 1'b0};
    vecs[4]  = '{1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0};
    vecs[5]  = '{1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0};
    vecs[6]  = '{1'b0, 2'b01, 2'b00, 1'b0, 1'b1, 2'b01, 2'b00, 1'b0};
    vecs[7]  = '{1'b0, 2'b01, 2'b00, 1'b1, 1'b0, 2'b01, 2'b01, 1'b0};
    vecs[8]  = '{1'b0, 2'b10, 2'b10, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0};
    vecs[9]  = '{1'b0, 2'b10, 2'b10, 1'b0, 1'b1, 2'b10, 2'b00, 1'b0};
    vecs[10] = '{1'b0, 2'b10, 2'b10, 1'b0, 1'b1, 2'b10, 2'b00, 1'b0};
    vecs[11] = '{1'b0, 2'b11, 2'b10, 1'b1, 1'b0, 2'b10, 2'b10, 1'b0};
    vecs[12] = '{1'b0, 2'b11, 2'b10, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0};
    vecs[13] = '{1'b0, 2'b01, 2'b00, 1'b0, 1'b1, 2'b01, 2'b00, 1'b0};
    vecs[14] = '{1'b0, 2'b01, 2'b00, 1'b0, 1'b1, 2'b01, 2'b00, 1'b0};
    vecs[15] = '{1'b1, 2'b01, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0};
    vecs[16] = '{1'b0, 2'b10, 2'b00, 1'b0, 1'b1, 2'b10, 2'b00, 1'b0};
    vecs[17] = '{1'b0, 2'b10, 2'b00, 1'b1, 1'b0, 2'b10, 2'b10, 1'b0};
    vecs[18] = '{1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0};

    rst        = 1'b1;
    req_enable = 2'b00;
    req_write  = 2'b00;
    req_addr   = {32'h0000_0080, 32'h0000_0400};
    req_data   = {A5, D0};
    mem_rdata  = DEAD;
    mem_ack    = 1'b0;
    en4        = 4'b0000;
    wr4        = 4'b0000;
    addr4      = {32'h0000_0300, 32'h0000_0200, 32'h0000_0100, 32'h0000_0000};
    data4      = {{8{32'h3333_3333}}, {8{32'h2222_2222}}, {8{32'h1111_1111}}, 256'h0};
    mem_rdata4 = 256'h0;
    mem_ack4   = 1'b0;

    // Cycle-by-cycle table: reset, reads, mask cycle, write, reset mid-BUSY.
    for (int i = 0; i < NV; i++) begin
      rst        = vecs[i].rst;
      req_enable = vecs[i].en;
      req_write  = vecs[i].wr;
      mem_ack    = vecs[i].ack;
      tick();
      check($sformatf("vec%0d mem_enable", i), mem_enable, vecs[i].exp_en);
      check($sformatf("vec%0d grant", i), grant, vecs[i].exp_grant);
      check($sformatf("vec%0d resp_ack", i), resp_ack, vecs[i].exp_ack);
      check($sformatf("vec%0d timeout", i), timeout, vecs[i].exp_to);
    end
    rst     = 1'b0;
    mem_ack = 1'b0;

    // Read of 0x400 on ch0, memory acks on the 10th BUSY cycle.
    req_enable = 2'b01;
    serve(10, 32'h400, 1'b0, D0, lat, ok);
    check("read latency", lat, 1);
    check("read busy window", ok, 1'b1);
    check("read mem_enable low", mem_enable, 1'b0);
    check("read resp_ack", resp_ack, 2'b01);
    check("read grant", grant, 2'b01);
    check("read resp_data", resp_data, DEAD);
    tick();
    check("read ack one cycle", resp_ack, 2'b00);
    check("read grant cleared", grant, 2'b00);
    req_enable = 2'b00;

    // Write of 0x80 on ch1, ack after 3 cycles; resp_data must hold.
    mem_rdata  = ALT;
    req_enable = 2'b10;
    req_write  = 2'b10;
    serve(3, 32'h80, 1'b1, A5, lat, ok);
    check("write latency", lat, 1);
    check("write busy window", ok, 1'b1);
    check("write resp_ack", resp_ack, 2'b10);
    check("write resp_data held", resp_data, DEAD);
    tick();
    check("write ack one cycle", resp_ack, 2'b00);
    req_enable = 2'b00;
    req_write  = 2'b00;
    mem_rdata  = DEAD;

    // Both channels request continuously: grants must alternate 0,1,0,1.
    req_enable = 2'b11;
    for (int j = 0; j < 4; j++) begin
      exp_g = (j % 2 == 0) ? 2'b01 : 2'b10;
      serve(2, (j % 2 == 0) ? 32'h400 : 32'h80, 1'b0, (j % 2 == 0) ? D0 : A5, lat, ok);
      check($sformatf("rr%0d busy window", j), ok, 1'b1);
      check($sformatf("rr%0d grant", j), grant, exp_g);
      check($sformatf("rr%0d resp_ack", j), resp_ack, exp_g);
    end
    req_enable = 2'b00;
    tick();
    tick();

    // Watchdog: memory never acks, abort after 16 BUSY cycles.
    mem_rdata  = WDDATA;
    req_enable = 2'b01;
    lat = 0;
    while (mem_enable !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    n = 0;
    while (mem_enable === 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check("wd busy cycles", n, 16);
    check("wd resp_ack", resp_ack, 2'b01);
    check("wd timeout set", timeout, 1'b1);
    check("wd resp_data held", resp_data, DEAD);
    tick();
    req_enable = 2'b00;
    mem_ack    = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("late ack mem_enable", mem_enable, 1'b0);
    check("late ack grant", grant, 2'b00);
    check("late ack resp_ack", resp_ack, 2'b00);
    check("late ack resp_data", resp_data, DEAD);
    tick();
    tick();
    check("timeout sticky", timeout, 1'b1);
    mem_rdata = DEAD;

    // Reset asserted during the 5th BUSY cycle, then a normal ch1 read.
    req_enable = 2'b01;
    lat = 0;
    while (mem_enable !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    repeat (4) tick();
    check("pre-reset still busy", mem_enable, 1'b1);
    rst = 1'b1;
    tick();
    check("rst mem_enable", mem_enable, 1'b0);
    check("rst grant", grant, 2'b00);
    check("rst resp_ack", resp_ack, 2'b00);
    check("rst timeout", timeout, 1'b0);
    check("rst resp_data", resp_data, 256'h0);
    rst        = 1'b0;
    req_enable = 2'b10;
    serve(2, 32'h80, 1'b0, A5, lat, ok);
    check("post-rst latency", lat, 1);
    check("post-rst busy window", ok, 1'b1);
    check("post-rst grant", grant, 2'b10);
    check("post-rst resp_ack", resp_ack, 2'b10);
    check("post-rst resp_data", resp_data, DEAD);
    tick();
    req_enable = 2'b00;

    // Four channels: serve ch1 so ptr=2, then ch1+ch3 -> ch3 first.
    en4 = 4'b0010;
    serve4(g4, a4, d4);
    check("n4 first grant", g4, 4'b0010);
    check("n4 first ack", ack4, 4'b0010);
    tick();
    en4 = 4'b0000;
    tick();
    en4 = 4'b1010;
    serve4(g4, a4, d4);
    check("n4 ptr2 grant", g4, 4'b1000);
    check("n4 ptr2 addr", a4, 32'h300);
    check("n4 ptr2 data", d4, {8{32'h3333_3333}});
    check("n4 ptr2 ack", ack4, 4'b1000);
    en4 = 4'b0010;
    serve4(g4, a4, d4);
    check("n4 second grant", g4, 4'b0010);
    check("n4 second addr", a4, 32'h100);
    check("n4 second ack", ack4, 4'b0010);
    en4 = 4'b0000;
    tick();
    check("n4 write flag", mem_wr4, 1'b0);
    check("n4 resp_data", rdata4, 256'h0);
    check("n4 timeout", to4, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
